// File: rtl/pattern_capture.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : pattern_capture                                            |
// | Description : Serial pattern receiver. On an accepted start pulse it     |
// |               samples din once per clock, assembles words MSB first,     |
// |               compares every word against a latched expected pattern     |
// |               and keeps a saturating per-run mismatch count.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous reset, active low
//   en           in   1      start pulse, honoured only while rdy=1
//   din          in   1      serial data, sampled every edge while capturing
//   pattern      in   WIDTH  expected word, latched at start
//   pattern_cnt  in   8      number of words minus one, latched at start
//   mask         in   WIDTH  compare mask, latched at start
//                            (only with PATTERN_CAPTURE_MASK_EN defined)
//   data         out  WIDTH  last assembled word
//   data_valid   out  1      one-cycle strobe for data/match/err_cnt update
//   match        out  1      last word equalled the (masked) pattern
//   err_cnt      out  ERR_W  mismatching words in current/last run, saturating
//   rdy          out  1      idle and able to accept en
//
// Build option:
//   PATTERN_CAPTURE_MASK_EN - adds the mask port; only bits set in mask take
//                             part in the compare (mask=0 matches every word).
//------------------------------------------------------------------------------
`default_nettype none

module pattern_capture #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic [WIDTH-1:0] pattern,
  input  logic [7:0]       pattern_cnt,
`ifdef PATTERN_CAPTURE_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             match,
  output logic [ERR_W-1:0] err_cnt,
  output logic             rdy
);

  localparam int c_bcw = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_bcw-1:0] c_last_bit = c_bcw'(WIDTH - 1);
  localparam logic [ERR_W-1:0] c_err_max  = {ERR_W{1'b1}};

  localparam logic [0:0] c_idle    = 1'b0;
  localparam logic [0:0] c_capture = 1'b1;

  logic [0:0]       state_q, state_d;

  logic [WIDTH-1:0] pat_q,   pat_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [c_bcw-1:0] bit_q,   bit_d;
  logic [7:0]       word_q,  word_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             dv_q,    dv_d;
  logic             match_q, match_d;
  logic [ERR_W-1:0] err_q,   err_d;
`ifdef PATTERN_CAPTURE_MASK_EN
  logic [WIDTH-1:0] mask_q,  mask_d;
`endif

  logic             w_accept;
  logic             w_capture;
  logic             w_word_done;
  logic             w_last_word;
  logic [WIDTH-1:0] w_word;
  logic             w_mismatch;

  // The word being completed includes the bit sampled on this very edge.
  assign w_word = {shreg_q[WIDTH-2:0], din};

`ifdef PATTERN_CAPTURE_MASK_EN
  assign w_mismatch = (((w_word ^ pat_q) & mask_q) != '0);
`else
  assign w_mismatch = (w_word != pat_q);
`endif

  // Word index is compared before it increments, so pattern_cnt=255 yields
  // 256 words without the 8-bit counter wrapping early.
  assign w_word_done = w_capture && (bit_q == c_last_bit);
  assign w_last_word = (word_q == cnt_q);

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_idle;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle: begin
        if (en) state_d = c_capture;
      end
      c_capture: begin
        if (w_word_done && w_last_word) state_d = c_idle;
      end
      default: state_d = c_idle;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    rdy       = (state_q == c_idle);
    w_capture = (state_q == c_capture);
    w_accept  = (state_q == c_idle) && en;
  end

  //--------------------------------------------------------------------------
  // Datapath next-state
  //--------------------------------------------------------------------------
  always_comb begin
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    word_d  = word_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    match_d = match_q;
    err_d   = err_q;
`ifdef PATTERN_CAPTURE_MASK_EN
    mask_d  = mask_q;
`endif

    if (w_accept) begin
      // data and match deliberately hold across a new start.
      pat_d   = pattern;
      cnt_d   = pattern_cnt;
      shreg_d = '0;
      bit_d   = '0;
      word_d  = '0;
      err_d   = '0;
`ifdef PATTERN_CAPTURE_MASK_EN
      mask_d  = mask;
`endif
    end else if (w_capture) begin
      shreg_d = w_word;
      bit_d   = bit_q + c_bcw'(1);
      if (w_word_done) begin
        bit_d   = '0;
        word_d  = word_q + 8'd1;
        data_d  = w_word;
        dv_d    = 1'b1;
        match_d = !w_mismatch;
        if (w_mismatch && (err_q != c_err_max)) begin
          err_d = err_q + ERR_W'(1);
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      match_q <= 1'b0;
      err_q   <= '0;
`ifdef PATTERN_CAPTURE_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      match_q <= match_d;
      err_q   <= err_d;
`ifdef PATTERN_CAPTURE_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign match      = match_q;
  assign err_cnt    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_capture.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_pattern_capture                                         |
// | Description : Directed self-checking bench for pattern_capture. A second |
// |               instance with ERR_W=2 shares all inputs to observe error   |
// |               counter saturation.                                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pattern_capture;

  logic       clk;
  logic       rst;
  logic       en;
  logic       din;
  logic [7:0] pattern;
  logic [7:0] pattern_cnt;
`ifdef PATTERN_CAPTURE_MASK_EN
  logic [7:0] mask;
`endif

  logic [7:0] data;
  logic       data_valid;
  logic       match;
  logic [7:0] err_cnt;
  logic       rdy;

  logic [7:0] s_data;
  logic       s_data_valid;
  logic       s_match;
  logic [1:0] s_err_cnt;
  logic       s_rdy;

  int tests_run    = 0;
  int tests_failed = 0;

  pattern_capture #(.WIDTH(8), .ERR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .pattern     (pattern),
    .pattern_cnt (pattern_cnt),
`ifdef PATTERN_CAPTURE_MASK_EN
    .mask        (mask),
`endif
    .data        (data),
    .data_valid  (data_valid),
    .match       (match),
    .err_cnt     (err_cnt),
    .rdy         (rdy)
  );

  pattern_capture #(.WIDTH(8), .ERR_W(2)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .pattern     (pattern),
    .pattern_cnt (pattern_cnt),
`ifdef PATTERN_CAPTURE_MASK_EN
    .mask        (mask),
`endif
    .data        (s_data),
    .data_valid  (s_data_valid),
    .match       (s_match),
    .err_cnt     (s_err_cnt),
    .rdy         (s_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 ns: inputs set here are seen by the next
  // edge, outputs read here reflect the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: shifts one byte in MSB first over 8 edges.
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      din = b[i];
      tick();
    end
  endtask

  task automatic start_run(input logic [7:0] pat, input logic [7:0] cnt);
    pattern     = pat;
    pattern_cnt = cnt;
    en          = 1'b1;
    tick();
    en          = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; din = 1'b0; pattern = 8'h00; pattern_cnt = 8'h00;
`ifdef PATTERN_CAPTURE_MASK_EN
    mask = 8'hFF;
`endif
    #12;
    tests_run++; if (rdy !== 1'b1)        begin tests_failed++; $display("FAIL reset_rdy got %b exp 1", rdy); end
    tests_run++; if (data !== 8'h00)      begin tests_failed++; $display("FAIL reset_data got %h exp 00", data); end
    tests_run++; if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dv got %b exp 0", data_valid); end
    tests_run++; if (match !== 1'b0)      begin tests_failed++; $display("FAIL reset_match got %b exp 0", match); end
    tests_run++; if (err_cnt !== 8'h00)   begin tests_failed++; $display("FAIL reset_err got %0d exp 0", err_cnt); end
    rst = 1'b1;
    tick();
    tests_run++; if (rdy !== 1'b1)        begin tests_failed++; $display("FAIL idle_rdy got %b exp 1", rdy); end
  endtask

  task automatic test_single_word();
    logic [7:0] b;
    logic       dv_seen;
    b = 8'h55;
    start_run(8'h55, 8'd0);
    tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL single_busy got %b exp 0", rdy); end
    dv_seen = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      din = b[i];
      tick();
      if (data_valid !== 1'b0) dv_seen = 1'b1;
    end
    tests_run++; if (dv_seen !== 1'b0) begin tests_failed++; $display("FAIL single_early_dv got %b exp 0", dv_seen); end
    din = b[0];
    tick();
    tests_run++; if (data !== 8'h55)      begin tests_failed++; $display("FAIL single_data got %h exp 55", data); end
    tests_run++; if (data_valid !== 1'b1) begin tests_failed++; $display("FAIL single_dv got %b exp 1", data_valid); end
    tests_run++; if (match !== 1'b1)      begin tests_failed++; $display("FAIL single_match got %b exp 1", match); end
    tests_run++; if (err_cnt !== 8'd0)    begin tests_failed++; $display("FAIL single_err got %0d exp 0", err_cnt); end
    tests_run++; if (rdy !== 1'b1)        begin tests_failed++; $display("FAIL single_rdy got %b exp 1", rdy); end
    tick();
    tests_run++; if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL single_dv_drop got %b exp 0", data_valid); end
    tests_run++; if (data !== 8'h55)      begin tests_failed++; $display("FAIL single_data_hold got %h exp 55", data); end
  endtask

  task automatic test_multi_word();
    logic [7:0] bytes [3]  = '{8'hAA, 8'hAB, 8'hAA};
    logic       exp_m [3]  = '{1'b1, 1'b0, 1'b1};
    logic [7:0] exp_e [3]  = '{8'd0, 8'd1, 8'd1};
    logic       exp_r [3]  = '{1'b0, 1'b0, 1'b1};
    start_run(8'hAA, 8'd2);
    for (int k = 0; k < 3; k++) begin
      send_byte(bytes[k]);
      tests_run++; if (data_valid !== 1'b1) begin tests_failed++; $display("FAIL multi_dv[%0d] got %b exp 1", k, data_valid); end
      tests_run++; if (data !== bytes[k])   begin tests_failed++; $display("FAIL multi_data[%0d] got %h exp %h", k, data, bytes[k]); end
      tests_run++; if (match !== exp_m[k])  begin tests_failed++; $display("FAIL multi_match[%0d] got %b exp %b", k, match, exp_m[k]); end
      tests_run++; if (err_cnt !== exp_e[k]) begin tests_failed++; $display("FAIL multi_err[%0d] got %0d exp %0d", k, err_cnt, exp_e[k]); end
      tests_run++; if (rdy !== exp_r[k])    begin tests_failed++; $display("FAIL multi_rdy[%0d] got %b exp %b", k, rdy, exp_r[k]); end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    start_run(8'h00, 8'd5);
    for (int k = 0; k < 6; k++) begin
      send_byte(8'hFF);
      tests_run++; if (s_data_valid !== 1'b1) begin tests_failed++; $display("FAIL sat_dv[%0d] got %b exp 1", k, s_data_valid); end
      tests_run++; if (s_data !== 8'hFF)      begin tests_failed++; $display("FAIL sat_data[%0d] got %h exp ff", k, s_data); end
      tests_run++; if (s_match !== 1'b0)      begin tests_failed++; $display("FAIL sat_match[%0d] got %b exp 0", k, s_match); end
      tests_run++; if (s_err_cnt !== exp_sat[k]) begin tests_failed++; $display("FAIL sat_err2[%0d] got %0d exp %0d", k, s_err_cnt, exp_sat[k]); end
      tests_run++; if (err_cnt !== 8'(k + 1)) begin tests_failed++; $display("FAIL sat_err8[%0d] got %0d exp %0d", k, err_cnt, k + 1); end
      tests_run++; if (s_rdy !== (k == 5))    begin tests_failed++; $display("FAIL sat_rdy[%0d] got %b exp %b", k, s_rdy, (k == 5)); end
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    logic [7:0] b;
    b = 8'h0F;
    start_run(8'h0F, 8'd1);
    for (int i = 7; i >= 0; i--) begin
      din = b[i];
      if (i == 5) begin
        en = 1'b1; pattern = 8'h0E; pattern_cnt = 8'd0;
      end else begin
        en = 1'b0;
      end
      tick();
    end
    tests_run++; if (data_valid !== 1'b1) begin tests_failed++; $display("FAIL ign_dv0 got %b exp 1", data_valid); end
    tests_run++; if (match !== 1'b1)      begin tests_failed++; $display("FAIL ign_match0 got %b exp 1", match); end
    tests_run++; if (err_cnt !== 8'd0)    begin tests_failed++; $display("FAIL ign_err0 got %0d exp 0", err_cnt); end
    tests_run++; if (rdy !== 1'b0)        begin tests_failed++; $display("FAIL ign_rdy0 got %b exp 0", rdy); end
    send_byte(8'h0E);
    tests_run++; if (data !== 8'h0E)      begin tests_failed++; $display("FAIL ign_data1 got %h exp 0e", data); end
    tests_run++; if (match !== 1'b0)      begin tests_failed++; $display("FAIL ign_match1 got %b exp 0", match); end
    tests_run++; if (err_cnt !== 8'd1)    begin tests_failed++; $display("FAIL ign_err1 got %0d exp 1", err_cnt); end
    tests_run++; if (rdy !== 1'b1)        begin tests_failed++; $display("FAIL ign_rdy1 got %b exp 1", rdy); end
    // Start the next run in the very cycle rdy came back.
    start_run(8'h81, 8'd0);
    tests_run++; if (rdy !== 1'b0)        begin tests_failed++; $display("FAIL b2b_accept got %b exp 0", rdy); end
    tests_run++; if (err_cnt !== 8'd0)    begin tests_failed++; $display("FAIL b2b_err_clr got %0d exp 0", err_cnt); end
    tests_run++; if (data !== 8'h0E)      begin tests_failed++; $display("FAIL b2b_data_hold got %h exp 0e", data); end
    tests_run++; if (match !== 1'b0)      begin tests_failed++; $display("FAIL b2b_match_hold got %b exp 0", match); end
    send_byte(8'h81);
    tests_run++; if (data !== 8'h81)      begin tests_failed++; $display("FAIL b2b_data got %h exp 81", data); end
    tests_run++; if (match !== 1'b1)      begin tests_failed++; $display("FAIL b2b_match got %b exp 1", match); end
    tests_run++; if (rdy !== 1'b1)        begin tests_failed++; $display("FAIL b2b_rdy got %b exp 1", rdy); end
  endtask

  task automatic test_reset_mid_capture();
    logic [7:0] b;
    b = 8'h3C;
    start_run(8'h3C, 8'd0);
    for (int i = 7; i >= 4; i--) begin
      din = b[i];
      tick();
    end
    tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy got %b exp 0", rdy); end
    #2;
    rst = 1'b0;
    #1;
    tests_run++; if (rdy !== 1'b1)        begin tests_failed++; $display("FAIL mid_rst_rdy got %b exp 1", rdy); end
    tests_run++; if (data !== 8'h00)      begin tests_failed++; $display("FAIL mid_rst_data got %h exp 00", data); end
    tests_run++; if (match !== 1'b0)      begin tests_failed++; $display("FAIL mid_rst_match got %b exp 0", match); end
    tests_run++; if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_dv got %b exp 0", data_valid); end
    #9;
    rst = 1'b1;
    tick();
    tests_run++; if (rdy !== 1'b1)        begin tests_failed++; $display("FAIL mid_post_rdy got %b exp 1", rdy); end
    tests_run++; if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_post_dv got %b exp 0", data_valid); end
    start_run(8'h3C, 8'd0);
    send_byte(8'h3C);
    tests_run++; if (data_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_rerun_dv got %b exp 1", data_valid); end
    tests_run++; if (data !== 8'h3C)      begin tests_failed++; $display("FAIL mid_rerun_data got %h exp 3c", data); end
    tests_run++; if (match !== 1'b1)      begin tests_failed++; $display("FAIL mid_rerun_match got %b exp 1", match); end
    tests_run++; if (err_cnt !== 8'd0)    begin tests_failed++; $display("FAIL mid_rerun_err got %0d exp 0", err_cnt); end
  endtask

`ifdef PATTERN_CAPTURE_MASK_EN
  task automatic test_mask();
    mask = 8'hF0;
    start_run(8'hF0, 8'd0);
    send_byte(8'hF7);
    tests_run++; if (match !== 1'b1)   begin tests_failed++; $display("FAIL mask_f0_match got %b exp 1", match); end
    tests_run++; if (err_cnt !== 8'd0) begin tests_failed++; $display("FAIL mask_f0_err got %0d exp 0", err_cnt); end
    mask = 8'hFF;
    start_run(8'hF0, 8'd0);
    send_byte(8'hF7);
    tests_run++; if (match !== 1'b0)   begin tests_failed++; $display("FAIL mask_ff_match got %b exp 0", match); end
    tests_run++; if (err_cnt !== 8'd1) begin tests_failed++; $display("FAIL mask_ff_err got %0d exp 1", err_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_multi_word();
    test_saturation();
    test_ignore_and_back_to_back();
    test_reset_mid_capture();
`ifdef PATTERN_CAPTURE_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pattern_capture.md
Name: pattern_capture

Overview:
- Serial receiver that is the counterpart of the pattern generator.
- On an enable pulse it samples a 1-bit line once per clock, assembles bytes MSB first and compares each byte against an expected pattern.
- Captures pattern_cnt+1 bytes, reports each byte with a match flag, and keeps a per-run error count.
- Sits on the glitch target's return path, so software can confirm the generated stimulus arrived intact.

Parameters:
- WIDTH, 8, bits per word; sizes pattern, data and the bit counter.
- ERR_W, 8, width of err_cnt; saturates at all-ones.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; 0 resets immediately.
- en  in  1  start pulse; sampled only while rdy=1.
- din  in  1  serial data in; sampled every clk edge while capturing.
- pattern  in  WIDTH  expected word; latched when en is accepted.
- pattern_cnt  in  8  word count minus one; latched when en is accepted (0 = one word).
- data  out  WIDTH  last assembled word.
- data_valid  out  1  one-cycle strobe; data, match and err_cnt are updated together with it.
- match  out  1  1 when the word on data equals the latched pattern.
- err_cnt  out  ERR_W  mismatching words in the current or most recent run.
- rdy  out  1  1 when idle and able to accept en.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; rdy=1.
  - data=0, data_valid=0, match=0, err_cnt=0.
  - Internal shift register, bit counter and word counter cleared.
- States:
  - IDLE:
    - rdy=1.
    - en=1 at edge E0: latch pattern and pattern_cnt, clear err_cnt, clear the counters, rdy<=0, go to CAPTURE.
  - CAPTURE:
    - rdy=0; en is ignored.
    - Each edge shifts din into the LSB (shreg <= {shreg[WIDTH-2:0], din}) and increments the bit counter.
    - First bit is sampled at E1.
- Word completion, on the edge where the bit counter reaches WIDTH-1:
  - data <= {shreg[WIDTH-2:0], din}.
  - data_valid <= 1 for exactly one cycle.
  - match <= (that word == latched pattern).
  - On mismatch, err_cnt <= err_cnt+1, saturating at 2^ERR_W-1.
  - Bit counter wraps to 0 and the word counter increments.
- Latency: the first word completes at edge E(WIDTH), i.e. E8 by default; word k (0-based) completes at E(8k+8).
- End of run:
  - When the completing word's index equals the latched pattern_cnt, the same edge sets rdy<=1 and returns to IDLE.
  - The final data_valid and rdy rise together.
  - pattern_cnt=255 gives 256 words; the word counter is 8 bits and compares before it increments, so no early wrap.
- Back-to-back: en asserted in the same cycle rdy is 1 after a run is accepted immediately. The previous data and match hold until overwritten; err_cnt clears.
- Input changes: pattern and pattern_cnt changing during CAPTURE have no effect.
- Reset mid-capture: aborts at once; all outputs return to reset values; no partial word is reported.
- Outputs hold between strobes: data and match hold their last value; data_valid is otherwise 0.

Optional Feature:
- PATTERN_CAPTURE_MASK_EN defined:
  - Adds input port mask [WIDTH-1:0], latched with pattern at en.
  - match = ((data ^ pattern) & mask) == 0; err_cnt counts masked mismatches only.
  - mask=0 means every word matches.
- Undefined: no mask port; full-width compare.

Test Plan:
- Reset, then en pulse with pattern=0x55 and pattern_cnt=0; drive din 0,1,0,1,0,1,0,1 on E1..E8 -> after E8: data=0x55, match=1, data_valid high for 1 cycle, err_cnt=0, rdy=1.
- pattern=0xAA, pattern_cnt=2; send 0xAA, 0xAB, 0xAA -> three strobes at E8/E16/E24; match 1,0,1; err_cnt=1; rdy rises at E24.
- Saturation with ERR_W=2: pattern=0x00, pattern_cnt=5, din held 1 -> every word is 0xFF with match=0; err_cnt reads 1,2,3,3,3,3.
- en pulsed at E3 of a run, and pattern changed mid-run -> ignored; run length and compare value unchanged; the next run, started the cycle rdy=1, clears err_cnt to 0.
- rst=0 asserted for 10 ns mid-word (between clock edges) -> outputs reset immediately with no edge required; no data_valid; rdy=1; a following run with pattern 0x3C captures 0x3C correctly.
- With PATTERN_CAPTURE_MASK_EN: pattern=0xF0, mask=0xF0, received 0xF7 -> match=1, err_cnt=0. With mask=0xFF -> match=0, err_cnt=1.
